call_setup: RTL and testbench

- Call-setup controller that sits directly upstream of the call accounting/billing block.
- Converts card presence, hook state, keypad digits and callee answer into the `on` and `category` signals consumed by billing.
- Consumes billing's `cut` output to force call release when credit is exhausted.
- Runs on the 4 Hz tick domain alongside billing.

---
 rtl/call_pkg.sv | 26 ++
 rtl/call_setup_if.sv | 25 ++
 rtl/call_timer.sv | 28 ++
 rtl/call_setup.sv | 204 ++++++++++++++++++++
 tb/tb_call_setup.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/call_pkg.sv
// Shared types and constants for the call-setup controller.
// Category encodings match the billing block's category input.
package call_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIAL,
        ST_RING,
        ST_TALK,
        ST_RELEASE
    } state_e;

    localparam logic [1:0] CAT_NONE    = 2'b00;
    localparam logic [1:0] CAT_LOCAL   = 2'b01;
    localparam logic [1:0] CAT_LONG    = 2'b10;
    localparam logic [1:0] CAT_SPECIAL = 2'b11;

    localparam logic [3:0] KEY_HASH      = 4'hB;
    localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;

    // Both timers share one width, sized for the longer timeout.
    function automatic int timer_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/call_setup_if.sv
// Subscriber-side signals of the call-setup controller: card, hook, keypad,
// callee answer and billing cut in; line/category/status out.
interface call_setup_if;
    logic       card;
    logic       offhook;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       answer;
    logic       cut;
    logic       on;
    logic [1:0] category;
    logic       dialing;
    logic       busy_tone;
    logic [3:0] digit_cnt;

    modport master (
        output card, offhook, key_valid, key_digit, answer, cut,
        input  on, category, dialing, busy_tone, digit_cnt
    );

    modport slave (
        input  card, offhook, key_valid, key_digit, answer, cut,
        output on, category, dialing, busy_tone, digit_cnt
    );
endinterface

// File: rtl/call_timer.sv
// Loadable down counter used for the dial and ring timeouts.
// Holds at zero; expired is high whenever the count is zero.
module call_timer #(
    parameter int W = 7
) (
    input  logic         clk_4Hz,
    input  logic         clrn,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_value,
    output logic         expired
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_4Hz or negedge clrn) begin
        if (!clrn) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_value;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/call_setup.sv
// Call-setup controller feeding the billing block (on/category) on the 4 Hz tick.
// Optional macro CALL_REDIAL_EN: '#' as first key replays the last call that reached RING.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | no card or handset down; waiting for card + offhook
// ST_DIAL    | collecting digits, dial timer running
// ST_RING    | number complete, waiting for callee, ring timer running
// ST_TALK    | callee answered, line connected to billing
// ST_RELEASE | call ended or timed out; busy tone until hang-up
module call_setup
    import call_pkg::*;
#(
    parameter int LOCAL_DIGITS   = 7,
    parameter int LONG_DIGITS    = 11,
    parameter int SPECIAL_DIGITS = 3,
    parameter int DIAL_TIMEOUT   = 40,
    parameter int RING_TIMEOUT   = 120
) (
    input logic         clk_4Hz,
    input logic         clrn,
    call_setup_if.slave bus
);

    localparam int TMR_W = timer_width(DIAL_TIMEOUT, RING_TIMEOUT);

    state_e     state_q, state_d;
    logic [1:0] cat_q, cat_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] req_q, req_d;
    logic       pend_q, pend_d;
    logic       on_q, dialing_q, busy_q;

    logic       dial_load, ring_load;
    logic       dial_expired, ring_expired;
    logic       abort, is_digit;
    logic [3:0] cnt_inc;

    assign abort    = !bus.card || !bus.offhook;
    assign is_digit = bus.key_valid && (bus.key_digit <= KEY_MAX_DIGIT);
    assign cnt_inc  = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

`ifdef CALL_REDIAL_EN
    logic       rd_valid_q;
    logic [1:0] rd_cat_q;
    logic [3:0] rd_cnt_q;
    logic       redial_hit;

    assign redial_hit = bus.key_valid && (bus.key_digit == KEY_HASH) &&
                        (cnt_q == 4'd0) && rd_valid_q;
`endif

    always_comb begin
        state_d   = state_q;
        cat_d     = cat_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        pend_d    = pend_q;
        dial_load = 1'b0;
        ring_load = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            cat_d   = CAT_NONE;
            cnt_d   = 4'd0;
            req_d   = 4'd0;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_DIAL;
                    dial_load = 1'b1;
                    cat_d     = CAT_NONE;
                    cnt_d     = 4'd0;
                    req_d     = 4'd0;
                    pend_d    = 1'b0;
                end
                ST_DIAL: begin
                    if (is_digit) begin
                        cnt_d     = cnt_inc;
                        dial_load = 1'b1;
                        if (cnt_q == 4'd0) begin
                            if (bus.key_digit == 4'd0) begin
                                req_d = 4'(LONG_DIGITS);
                                cat_d = CAT_LONG;
                            end else if (bus.key_digit == 4'd1) begin
                                pend_d = 1'b1;
                            end else begin
                                req_d = 4'(LOCAL_DIGITS);
                                cat_d = CAT_LOCAL;
                            end
                        end else if (pend_q) begin
                            // a leading '1' is only resolved by the second digit
                            pend_d = 1'b0;
                            if (bus.key_digit == 4'd1) begin
                                req_d = 4'(SPECIAL_DIGITS);
                                cat_d = CAT_SPECIAL;
                            end else begin
                                req_d = 4'(LONG_DIGITS);
                                cat_d = CAT_LONG;
                            end
                        end
                        if (cnt_inc == req_d) begin
                            state_d   = ST_RING;
                            ring_load = 1'b1;
                        end
                    end
`ifdef CALL_REDIAL_EN
                    else if (redial_hit) begin
                        cat_d     = rd_cat_q;
                        cnt_d     = rd_cnt_q;
                        req_d     = rd_cnt_q;
                        state_d   = ST_RING;
                        ring_load = 1'b1;
                    end
`endif
                    else if (dial_expired) begin
                        state_d = ST_RELEASE;
                    end
                end
                ST_RING: begin
                    if (bus.answer) begin
                        state_d = ST_TALK;
                    end else if (ring_expired) begin
                        state_d = ST_RELEASE;
                    end
                end
                ST_TALK: begin
                    if (bus.cut || !bus.answer) begin
                        state_d = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    cat_d = CAT_NONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Line/status outputs follow the registered state one tick later.
    always_ff @(posedge clk_4Hz or negedge clrn) begin
        if (!clrn) begin
            state_q   <= ST_IDLE;
            cat_q     <= CAT_NONE;
            cnt_q     <= 4'd0;
            req_q     <= 4'd0;
            pend_q    <= 1'b0;
            on_q      <= 1'b0;
            dialing_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cat_q     <= cat_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            pend_q    <= pend_d;
            on_q      <= !abort && (state_q == ST_TALK);
            dialing_q <= !abort && (state_q == ST_DIAL);
            busy_q    <= !abort && (state_q == ST_RELEASE);
        end
    end

`ifdef CALL_REDIAL_EN
    // The stored call survives hang-up; only reset invalidates it.
    always_ff @(posedge clk_4Hz or negedge clrn) begin
        if (!clrn) begin
            rd_valid_q <= 1'b0;
            rd_cat_q   <= CAT_NONE;
            rd_cnt_q   <= 4'd0;
        end else if ((state_q == ST_DIAL) && (state_d == ST_RING)) begin
            rd_valid_q <= 1'b1;
            rd_cat_q   <= cat_d;
            rd_cnt_q   <= req_d;
        end
    end
`endif

    call_timer #(.W(TMR_W)) u_dial_timer (
        .clk_4Hz    (clk_4Hz),
        .clrn       (clrn),
        .load       (dial_load),
        .en         (state_q == ST_DIAL),
        .load_value (TMR_W'(DIAL_TIMEOUT)),
        .expired    (dial_expired)
    );

    call_timer #(.W(TMR_W)) u_ring_timer (
        .clk_4Hz    (clk_4Hz),
        .clrn       (clrn),
        .load       (ring_load),
        .en         (state_q == ST_RING),
        .load_value (TMR_W'(RING_TIMEOUT)),
        .expired    (ring_expired)
    );

    assign bus.on        = on_q;
    assign bus.category  = cat_q;
    assign bus.dialing   = dialing_q;
    assign bus.busy_tone = busy_q;
    assign bus.digit_cnt = cnt_q;

endmodule

// File: tb/tb_call_setup.sv
// Scoreboard bench for call_setup: expectations are queued with each stimulus
// step and compared just after the following clock edge.
module tb_call_setup;
    import call_pkg::*;

    localparam int S_ON   = 0;
    localparam int S_CAT  = 1;
    localparam int S_DIAL = 2;
    localparam int S_BUSY = 3;
    localparam int S_CNT  = 4;

    typedef struct {
        string tag;
        int    sel;
        int    val;
    } exp_t;

    logic clk_4Hz = 1'b0;
    logic clrn;
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    call_setup_if bus();

    call_setup dut (
        .clk_4Hz (clk_4Hz),
        .clrn    (clrn),
        .bus     (bus.slave)
    );

    always #5 clk_4Hz = ~clk_4Hz;

    initial begin
        #100000;
        $display("FAIL watchdog: got still running, want finished");
        $fatal(1, "watchdog expired");
    end

    function automatic int actual(input int sel);
        case (sel)
            S_ON:    return int'(bus.on);
            S_CAT:   return int'(bus.category);
            S_DIAL:  return int'(bus.dialing);
            S_BUSY:  return int'(bus.busy_tone);
            default: return int'(bus.digit_cnt);
        endcase
    endfunction

    task automatic check_val(input string tag, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp_v);
        end
    endtask

    task automatic want(input string tag, input int sel, input int v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic want_all(input string tag, input int on_v, input int cat_v,
                            input int dial_v, input int busy_v, input int cnt_v);
        want({tag, ".on"},   S_ON,   on_v);
        want({tag, ".cat"},  S_CAT,  cat_v);
        want({tag, ".dial"}, S_DIAL, dial_v);
        want({tag, ".busy"}, S_BUSY, busy_v);
        want({tag, ".cnt"},  S_CNT,  cnt_v);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_val(e.tag, actual(e.sel), e.val);
        end
    endtask

    task automatic step();
        @(posedge clk_4Hz);
        #1;
        drain();
    endtask

    task automatic press(input logic [3:0] d, input int cnt_v, input int cat_v,
                         input string tag);
        bus.key_valid = 1'b1;
        bus.key_digit = d;
        want({tag, ".cnt"}, S_CNT, cnt_v);
        want({tag, ".cat"}, S_CAT, cat_v);
        step();
        bus.key_valid = 1'b0;
        bus.key_digit = 4'd0;
    endtask

    task automatic go_off_hook(input string tag);
        bus.offhook = 1'b1;
        step();
        want({tag, ".dial"}, S_DIAL, 1);
        want({tag, ".cnt"},  S_CNT,  0);
        want({tag, ".cat"},  S_CAT,  0);
        step();
    endtask

    logic [3:0] long_num [11];
    logic [3:0] local_num [7];

    initial begin
        long_num  = '{4'd0, 4'd1, 4'd0, 4'd5, 4'd5, 4'd5, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        local_num = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};

        clrn          = 1'b0;
        bus.card      = 1'b0;
        bus.offhook   = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_digit = 4'd0;
        bus.answer    = 1'b0;
        bus.cut       = 1'b0;
        #12;
        want_all("rst", 0, 0, 0, 0, 0);
        drain();
        clrn = 1'b1;
        step();

        // '#' after reset and a non-digit key are ignored; then dial timeout.
        bus.card = 1'b1;
        go_off_hook("c.hook");
        press(KEY_HASH, 0, 0, "c.hash");
        press(4'hC, 0, 0, "c.keyc");
        press(4'd3, 1, 1, "c.d1");
        press(4'd5, 2, 1, "c.d2");
        press(4'd7, 3, 1, "c.d3");
        // timer reloads to 40 on the last key, reaches 0 40 ticks later,
        // the state leaves DIAL on the next tick and busy_tone follows one tick after
        for (int i = 0; i < 40; i++) step();
        want("c.pre.dial", S_DIAL, 1);
        want("c.pre.busy", S_BUSY, 0);
        step();
        want_all("c.rel", 0, 0, 0, 1, 3);
        step();
        bus.offhook = 1'b0;
        want_all("c.hang", 0, 0, 0, 0, 0);
        step();

        // Long-distance call, answered, then cut by billing.
        go_off_hook("a.hook");
        for (int i = 0; i < 11; i++) press(long_num[i], i + 1, 2, "a.dig");
        bus.answer = 1'b1;
        want("a.ring.on", S_ON, 0);
        step();
        want_all("a.talk", 1, 2, 0, 0, 11);
        step();
        bus.cut = 1'b1;
        step();
        bus.cut = 1'b0;
        want_all("a.cut", 0, 0, 0, 1, 11);
        step();
        bus.answer  = 1'b0;
        bus.offhook = 1'b0;
        want_all("a.hang", 0, 0, 0, 0, 0);
        step();

        // Special-service call, then reset pulse mid-TALK.
        go_off_hook("b.hook");
        press(4'd1, 1, 0, "b.d1");
        press(4'd1, 2, 3, "b.d2");
        press(4'd0, 3, 3, "b.d3");
        want("b.ring.dial", S_DIAL, 0);
        want("b.ring.on",   S_ON,   0);
        step();
        bus.answer = 1'b1;
        step();
        want_all("b.talk", 1, 3, 0, 0, 3);
        step();
        #2;
        clrn = 1'b0;
        #1;
        want_all("b.rst", 0, 0, 0, 0, 0);
        drain();
        bus.answer  = 1'b0;
        bus.offhook = 1'b0;
        #3;
        clrn = 1'b1;
        step();

        // Local call; card pulled while ringing.
        go_off_hook("d.hook");
        for (int i = 0; i < 7; i++) press(local_num[i], i + 1, 1, "d.dig");
        want("d.ring.dial", S_DIAL, 0);
        step();
        bus.card = 1'b0;
        want_all("d.card", 0, 0, 0, 0, 0);
        step();
        bus.offhook = 1'b0;
        step();
        bus.card = 1'b1;
        step();
        go_off_hook("r.hook");

`ifdef CALL_REDIAL_EN
        press(KEY_HASH, 7, 1, "r.hash");
        want("r.ring.dial", S_DIAL, 0);
        step();
        bus.answer = 1'b1;
        step();
        want_all("r.talk", 1, 1, 0, 0, 7);
        step();
        bus.answer = 1'b0;
        step();
        want_all("r.drop", 0, 0, 0, 1, 7);
        step();
`else
        press(KEY_HASH, 0, 0, "r.hash");
        want("r.still.dial", S_DIAL, 1);
        step();
        press(4'd0, 1, 2, "r.d1");
`endif
        bus.offhook = 1'b0;
        want_all("r.hang", 0, 0, 0, 0, 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
